// File: rtl/sha3_pad_buffer.sv
// rtl/sha3_pad_buffer.sv - SHA3 rate-block assembler (576-bit rate) with 0x06..0x80 padding
module sha3_pad_buffer (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [31:0]  in,
  input  logic         in_ready,
  input  logic         is_last,
  input  logic [1:0]   byte_num,
  output logic         buffer_full,
  output logic [575:0] out,
  input  logic         f_ack,
  output logic         in_accept
);

  localparam logic [1:0] ACCEPT = 2'd0;
  localparam logic [1:0] PAD    = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  logic [1:0]  state;
  logic [4:0]  count;
  logic [31:0] pad_word;
  logic [31:0] wr_data;
  logic        wr_en;
  logic        last_slot;

  assign in_accept = reset_n & in_ready & ~buffer_full & (state == ACCEPT);
  assign last_slot = (count == 5'd17);

  // Domain-separation byte 0x06 goes right after the last valid message byte.
  always_comb begin
    pad_word = 32'h0600_0000;
    case (byte_num)
      2'd0: pad_word = 32'h0600_0000;
      2'd1: pad_word = {in[31:24], 24'h06_0000};
      2'd2: pad_word = {in[31:16], 16'h0600};
      2'd3: pad_word = {in[31:8], 8'h06};
      default: pad_word = 32'h0600_0000;
    endcase
  end

  always_comb begin
    wr_en   = 1'b0;
    wr_data = 32'h0;
    if (!buffer_full) begin
      if (in_accept) begin
        wr_en   = 1'b1;
        wr_data = is_last ? pad_word : in;
        if (is_last && last_slot) wr_data[7:0] = wr_data[7:0] | 8'h80;
      end else if (state == PAD) begin
        wr_en   = 1'b1;
        wr_data = last_slot ? 32'h0000_0080 : 32'h0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out         <= '0;
      count       <= 5'd0;
      buffer_full <= 1'b0;
      state       <= ACCEPT;
    end else if (buffer_full) begin
      if (f_ack) begin
        buffer_full <= 1'b0;
        count       <= 5'd0;
      end
    end else if (wr_en) begin
      out   <= {out[543:0], wr_data};
      count <= count + 5'd1;
      if (last_slot) buffer_full <= 1'b1;
      if (state == ACCEPT && is_last) begin
        state <= last_slot ? DONE : PAD;
      end else if (state == PAD && last_slot) begin
        state <= DONE;
      end
    end
  end

endmodule

// File: tb/tb_sha3_pad_buffer.sv
// tb/tb_sha3_pad_buffer.sv - scoreboard bench for sha3_pad_buffer
module tb_sha3_pad_buffer;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [31:0]  in = 32'h0;
  logic         in_ready = 1'b0;
  logic         is_last = 1'b0;
  logic [1:0]   byte_num = 2'd0;
  logic         buffer_full;
  logic [575:0] out;
  logic         f_ack = 1'b0;
  logic         in_accept;

  int checks = 0;
  int errors = 0;
  logic [575:0] exp_q[$];
  logic [31:0]  words[18];
  logic         bf_q = 1'b0;
  logic [575:0] snap;

  sha3_pad_buffer dut (
    .clk(clk), .reset_n(reset_n), .in(in), .in_ready(in_ready), .is_last(is_last),
    .byte_num(byte_num), .buffer_full(buffer_full), .out(out), .f_ack(f_ack),
    .in_accept(in_accept)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [575:0] act, input logic [575:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic clear_words();
    for (int i = 0; i < 18; i++) words[i] = 32'h0;
  endtask

  task automatic push_exp();
    logic [575:0] b;
    b = '0;
    for (int i = 0; i < 18; i++) b = {b[543:0], words[i]};
    exp_q.push_back(b);
  endtask

  // Monitor: compare each newly completed block against the scoreboard.
  always @(negedge clk) begin
    if (buffer_full && !bf_q) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_block: got %0h expected none", out);
      end else begin
        chk("block", out, exp_q.pop_front());
      end
    end
    bf_q = buffer_full;
  end

  task automatic send(input logic [31:0] w, input logic last, input logic [1:0] bn);
    int n;
    in = w; is_last = last; byte_num = bn; in_ready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_accept && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    in_ready = 1'b0; is_last = 1'b0;
  endtask

  task automatic wait_full(output int n);
    n = 0;
    while (!buffer_full && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) chk("full_timeout", 0, 1);
  endtask

  task automatic ack();
    @(posedge clk); #1 f_ack = 1'b1;
    @(posedge clk); #1 f_ack = 1'b0;
  endtask

  task automatic do_reset();
    #3 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic ok;
    // Reset state, with in_ready held high during reset
    in_ready = 1'b1;
    #7;
    chk("rst_out", out, '0);
    chk("rst_full", buffer_full, 0);
    chk("rst_accept", in_accept, 0);
    in_ready = 1'b0;
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;

    // Empty message
    clear_words();
    words[0] = 32'h0600_0000; words[17] = 32'h0000_0080;
    push_exp();
    send(32'hDEAD_BEEF, 1'b1, 2'd0);
    wait_full(n);
    chk("empty_latency", n, 18);
    ack();
    @(negedge clk);
    chk("ack_clears_full", buffer_full, 0);
    snap = out;
    // DONE: input ignored for 20 cycles
    in = 32'h1234_5678; in_ready = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_accept || buffer_full || out !== snap) ok = 1'b0;
    end
    in_ready = 1'b0;
    chk("done_idle", ok, 1);

    // 17 full words + 3-byte last word lands as word 18
    do_reset();
    clear_words();
    for (int i = 0; i < 17; i++) words[i] = 32'h1122_3344;
    words[17] = 32'hAABB_CC86;
    push_exp();
    for (int i = 0; i < 17; i++) send(32'h1122_3344, 1'b0, 2'd3);
    send(32'hAABB_CCDD, 1'b1, 2'd3);
    wait_full(n);
    chk("w18_low_word", out[31:0], 32'hAABB_CC86);
    ack();
    in_ready = 1'b1;
    @(negedge clk);
    chk("w18_done_accept", in_accept, 0);
    in_ready = 1'b0;

    // 18 raw words, then 1-byte last word into a second block
    do_reset();
    clear_words();
    for (int i = 0; i < 18; i++) words[i] = 32'hA000_0000 + i;
    push_exp();
    clear_words();
    words[0] = 32'h5506_0000; words[17] = 32'h0000_0080;
    push_exp();
    for (int i = 0; i < 18; i++) send(32'hA000_0000 + i, 1'b0, 2'd2);
    in = 32'h55AB_CDEF; is_last = 1'b1; byte_num = 2'd1; in_ready = 1'b1;
    @(negedge clk);
    snap = out;
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (in_accept || !buffer_full || out !== snap) ok = 1'b0;
      @(negedge clk);
    end
    chk("hold_stable", ok, 1);
    @(posedge clk); #1 f_ack = 1'b1;
    @(negedge clk);
    chk("ack_cycle_accept", in_accept, 0);
    @(posedge clk); #1 f_ack = 1'b0;
    @(negedge clk);
    chk("post_ack_accept", in_accept, 1);
    chk("post_ack_full", buffer_full, 0);
    @(posedge clk); #1 in_ready = 1'b0; is_last = 1'b0;
    wait_full(n);
    chk("blk2_first", out[575:544], 32'h5506_0000);
    ack();

    // Asynchronous reset during PAD
    do_reset();
    for (int i = 0; i < 3; i++) send(32'hCAFE_0000 + i, 1'b0, 2'd0);
    send(32'hBEEF_0000, 1'b1, 2'd2);
    repeat (5) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk("async_out", out, '0);
    chk("async_full", buffer_full, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    clear_words();
    words[0] = 32'h9A06_0000; words[17] = 32'h0000_0080;
    push_exp();
    send(32'h9A12_3456, 1'b1, 2'd1);
    wait_full(n);
    ack();

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
